prog_rom_loader: RTL
====================

# prog_rom_loader

Writer side of the FSM microcode interface. Receives a byte stream carrying a microcode program, packs it into 26-bit instruction words, and stores them in an internal 512-entry program memory. Serves the FSM's `rom_addr`/`rom_q` read port with one-cycle registered latency. Holds the FSM in reset until a complete program has been loaded.

## Interface
Parameters:
- `ADDR_W`, 9, program memory address width; depth is 2^ADDR_W.
- `WORD_W`, 26, instruction width, packed as {dest[5:0], src1[5:0], op[1:0], times[5:0], src2[5:0]}.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte; transfer occurs when `in_valid & in_ready` at a rising edge.
- `rom_addr`  in  ADDR_W  FSM read address.
- `rom_q`  out  WORD_W  registered read data, `mem[rom_addr]` from the previous edge.
- `fsm_reset`  out  1  active-high reset to the FSM.
- `loaded`  out  1  program complete; FSM released.
- `err`  out  1  malformed length header; sticky.

## Operation
- Stream format:
  - Two length bytes, big-endian N, giving the word count.
  - Then N words, each 4 bytes big-endian.
  - Bits [7:2] of each word's first byte are discarded; the low 26 bits of the 32-bit word form the instruction.
- Valid N: 1..2^ADDR_W. N=0 or N>2^ADDR_W: go to ERR after the second length byte.
- States and transitions:
  - LEN_HI: on accept, latch N[15:8]; go to LEN_LO.
  - LEN_LO: on accept, latch N[7:0]; go to WORD if N is valid, else ERR.
  - WORD: accept bytes into a shift register; 2-bit byte index counts 0..3. On accepting byte 3:
    - write the assembled word to `mem[wptr]` in that same edge;
    - increment `wptr`, which starts at 0.
    - If `wptr == N-1`, go to RUN; else reset the byte index and stay in WORD.
  - RUN: terminal. `in_ready=0`, `fsm_reset=0`, `loaded=1`.
  - ERR: terminal. `in_ready=0`, `fsm_reset=1`, `err=1`.
- Leaving RUN or ERR requires `reset`.
- `in_ready=1` exactly in LEN_HI, LEN_LO and WORD. It is registered from state, with no combinational path from `in_valid`.
- Read port runs in every state: `rom_q <= mem[rom_addr]` each edge. Reads during loading return whatever is stored (undefined before the first write).
- Read and write of the same address on the same edge: read returns the old data.
- Words beyond N are not written and keep prior contents.

## Timing
- Reset values: state=LEN_HI, `in_ready=1`, `fsm_reset=1`, `loaded=0`, `err=0`, `rom_q=0`, `wptr=0`, byte index 0. Memory contents are not reset.
- Throughput: one byte per cycle; no bubbles between words.
- Final word: written on the edge that accepts its 4th byte. From that edge's next cycle, `fsm_reset=0` and `loaded=1`.
- FSM's first `rom_addr=0` read therefore returns the final program contents.
- Read latency: exactly 1 cycle from `rom_addr` to `rom_q`.
- `in_valid` low mid-word: hold state and partial word indefinitely.
- Reset asserted mid-load: immediate return to reset values. A partial word is dropped; memory keeps already-written words.

## Structure
- Shared package `fsm_pkg` holds:
  - op codes ADD=2'd0, SUB=2'd1, CUBIC=2'd2, MULT=2'd3;
  - field bit positions of the 26-bit instruction;
  - loader state encoding.
- FSM and testbenches import the same package.
- Sub-module `prog_mem`: simple dual-port array (one write port, one registered read port, read-old-on-collision), parameterised by ADDR_W/WORD_W.

## Test plan
- Load N=4 with words {10,11,ADD,1,12}, {20,21,SUB,1,22}, {30,31,CUBIC,5,32}, {40,41,MULT,33,42}:
  - `loaded` rises the cycle after byte 18 is accepted;
  - `rom_addr`=0..3 returns each word one cycle later.
- Same load with `in_valid` randomly deasserted (~50%): identical memory contents; `fsm_reset` stays 1 until the last byte.
- Header 0x0000 -> `err=1`, `in_ready=0`, `fsm_reset=1`. Header 0x0201 -> same.
- First word byte 0 = 0xFF -> stored word has bits [25:24]=2'b11, and bits [31:26] are ignored.
- Reset asserted after 2 of 3 words -> outputs return to reset values immediately. A reload of N=1 then succeeds, with `mem[0]` = the new word and `mem[1]` = the old word.
- N=512 full load -> `wptr` wraps to 0 without writing past entry 511; `rom_addr`=511 returns the last word.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the microcode FSM and its program loader: opcodes,
// instruction field layout and loader state encoding.
package fsm_pkg;

   typedef enum logic [1:0] {
      OpAdd   = 2'd0,
      OpSub   = 2'd1,
      OpCubic = 2'd2,
      OpMult  = 2'd3
   } op_e;

   // 26-bit instruction: dest[25:20] src1[19:14] op[13:12] times[11:6] src2[5:0]
   typedef struct packed {
      logic [5:0] dest;
      logic [5:0] src1;
      op_e        op;
      logic [5:0] times;
      logic [5:0] src2;
   } instr_t;

   typedef enum logic [2:0] {
      StLenHi = 3'd0,
      StLenLo = 3'd1,
      StWord  = 3'd2,
      StRun   = 3'd3,
      StErr   = 3'd4
   } loader_state_e;

endpackage

// File: rtl/prog_mem.sv
// Simple dual-port program memory: one write port, one registered read port.
// A read and write to the same address on one edge returns the old word.
module prog_mem #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned WORD_W = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/prog_rom_loader.sv
// Loads a length-prefixed byte stream of microcode words into program memory and
// holds the FSM in reset until the whole program is present.
module prog_rom_loader
   import fsm_pkg::*;
#(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned WORD_W = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rom_addr,
   output logic [WORD_W-1:0] rom_q,
   output logic              fsm_reset,
   output logic              loaded,
   output logic              err
);

   localparam int unsigned Depth = 2**ADDR_W;

   loader_state_e     state_q;
   logic [7:0]        len_hi_q;
   logic [ADDR_W-1:0] last_q;
   logic [ADDR_W-1:0] wptr_q;
   logic [1:0]        byte_idx_q;
   logic [WORD_W-9:0] shift_q;

   logic              accept;
   logic [15:0]       n_word;
   logic              n_valid;
   logic              mem_we;
   logic [WORD_W-1:0] mem_wdata;

   always_comb begin
      accept    = in_valid & in_ready;
      n_word    = {len_hi_q, in_data};
      n_valid   = (n_word != 16'd0) && (32'(n_word) <= Depth);
      mem_we    = accept && (state_q == StWord) && (byte_idx_q == 2'd3);
      // Earlier bytes already had their discarded high bits shifted out.
      mem_wdata = {shift_q, in_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StLenHi;
         len_hi_q   <= '0;
         last_q     <= '0;
         wptr_q     <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         in_ready   <= 1'b1;
         fsm_reset  <= 1'b1;
         loaded     <= 1'b0;
         err        <= 1'b0;
      end else if (accept) begin
         case (state_q)
            StLenHi: begin
               len_hi_q <= in_data;
               state_q  <= StLenLo;
            end
            StLenLo: begin
               last_q <= ADDR_W'(n_word - 16'd1);
               if (n_valid) begin
                  state_q <= StWord;
               end else begin
                  state_q  <= StErr;
                  in_ready <= 1'b0;
                  err      <= 1'b1;
               end
            end
            StWord: begin
               shift_q    <= {shift_q[WORD_W-17:0], in_data};
               byte_idx_q <= byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  wptr_q <= wptr_q + ADDR_W'(1);
                  if (wptr_q == last_q) begin
                     state_q   <= StRun;
                     in_ready  <= 1'b0;
                     fsm_reset <= 1'b0;
                     loaded    <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   prog_mem #(
      .ADDR_W(ADDR_W),
      .WORD_W(WORD_W)
   ) u_prog_mem (
      .clk  (clk),
      .reset(reset),
      .we   (mem_we),
      .waddr(wptr_q),
      .wdata(mem_wdata),
      .raddr(rom_addr),
      .rdata(rom_q)
   );

endmodule
